// File: rtl/fc_l2_arb_pkg.sv
// Shared definitions for the FC L2 arbiter.
// Contents:
//   MAX_N_REQ - largest supported number of requester ports
//   req_idx_t - requester index type, wide enough for MAX_N_REQ requesters
//   rr_pick   - round-robin search: the first set request at or after ptr,
//               wrapping modulo n
package fc_l2_arb_pkg;

    localparam int MAX_N_REQ = 8;

    typedef logic [2:0] req_idx_t;

    // Requests at or above index n are ignored. If no request is set, the
    // result is 0. Callers only use the result when some request is set.
    function automatic req_idx_t rr_pick(input logic [MAX_N_REQ-1:0] req,
                                         input req_idx_t              ptr,
                                         input int                    n);
        req_idx_t win;
        logic     found;
        int       idx;
        win   = '0;
        found = 1'b0;
        for (int i = 0; i < MAX_N_REQ; i++) begin
            if (i < n) begin
                idx = (int'(ptr) + i) % n;
                if (!found && req[idx]) begin
                    win   = req_idx_t'(idx);
                    found = 1'b1;
                end
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/fc_l2_arb_id_fifo.sv
// Grant-order FIFO of requester indices. Each entry records who owns one
// outstanding transaction.
// Ports:
//   clk, rst_n - clock and synchronous active-low reset
//   push, din  - enqueue din. Ignored when the FIFO is full.
//   pop        - dequeue the head entry. Ignored when the FIFO is empty.
//   dout       - head entry. Not meaningful when the FIFO is empty.
//   full, empty, count - occupancy status
import fc_l2_arb_pkg::*;

module fc_l2_arb_id_fifo #(
    parameter  int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  req_idx_t         din,
    output req_idx_t         dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    req_idx_t         mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             push_ok;
    logic             pop_ok;

    // The pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop_ok) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            if (push_ok && !pop_ok) begin
                count_q <= count_q + 1'b1;
            end else if (pop_ok && !push_ok) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/fc_l2_arbiter.sv
// Shares one FC L2 TCDM-style master port (req/gnt handshake, in-order
// r_valid) between N_REQ requesters, using round-robin arbitration. A FIFO
// records the grant order so that each response goes back to the requester
// that issued it.
//
// Build option FC_L2_ARB_FIXED_PRIO_EN: when defined, requester 0 has
// absolute priority. Requesters 1..N_REQ-1 share round-robin among
// themselves, and the round-robin pointer advances only on their grants.
//
// Handshake: a requester holds req and its payload stable until gnt. gnt is
// given in the same cycle as m_gnt_i. Responses come back strictly in grant
// order, one or more cycles after the grant. While a request is stalled
// (m_req_o=1, m_gnt_i=0), the winner is locked, so the master port never
// sees its request change under it.
//
// Ports:
//   clk_i, rst_ni                 - clock and synchronous active-low reset
//   req_i/add_i/wen_i/wdata_i/be_i - per-requester request and packed payload
//   gnt_o, r_valid_o, r_rdata_o   - per-requester grant, response valid, and
//                                   response data (broadcast to all)
//   m_*                           - shared master port
//   busy_o                        - at least one transaction outstanding
//   err_o                         - sticky: a response arrived while nothing
//                                   was outstanding
import fc_l2_arb_pkg::*;

module fc_l2_arbiter #(
    parameter int N_REQ           = 2,
    parameter int MAX_OUTSTANDING = 4,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [N_REQ-1:0]              req_i,
    input  logic [N_REQ*ADDR_WIDTH-1:0]   add_i,
    input  logic [N_REQ-1:0]              wen_i,
    input  logic [N_REQ*DATA_WIDTH-1:0]   wdata_i,
    input  logic [N_REQ*DATA_WIDTH/8-1:0] be_i,
    output logic [N_REQ-1:0]              gnt_o,
    output logic [N_REQ-1:0]              r_valid_o,
    output logic [DATA_WIDTH-1:0]         r_rdata_o,
    output logic                          m_req_o,
    output logic [ADDR_WIDTH-1:0]         m_add_o,
    output logic                          m_wen_o,
    output logic [DATA_WIDTH-1:0]         m_wdata_o,
    output logic [DATA_WIDTH/8-1:0]       m_be_o,
    input  logic                          m_gnt_i,
    input  logic                          m_r_valid_i,
    input  logic [DATA_WIDTH-1:0]         m_r_rdata_i,
    output logic                          busy_o,
    output logic                          err_o
);

    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    req_idx_t             rr_q;
    req_idx_t             lock_idx_q;
    logic                 lock_q;
    logic                 err_q;
    req_idx_t             pick;
    req_idx_t             winner;
    req_idx_t             rr_next;
    req_idx_t             head;
    logic                 rr_adv;
    logic                 handshake;
    logic                 rsp_valid;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [CNT_W-1:0]     count;
    logic [MAX_N_REQ-1:0] req_ext;

    always_comb begin
        req_ext             = '0;
        req_ext[N_REQ-1:0]  = req_i;
    end

`ifdef FC_L2_ARB_FIXED_PRIO_EN
    localparam logic [MAX_N_REQ-1:0] REQ0_MASK = MAX_N_REQ'(1);

    always_comb begin
        if (req_i[0]) begin
            pick = '0;
        end else begin
            pick = rr_pick(req_ext & ~REQ0_MASK, rr_q, N_REQ);
        end
    end
    assign rr_adv = (winner != '0);
`else
    assign pick   = rr_pick(req_ext, rr_q, N_REQ);
    assign rr_adv = 1'b1;
`endif

    // A stalled winner keeps the port for as long as it keeps requesting.
    assign winner = (lock_q && req_ext[lock_idx_q]) ? lock_idx_q : pick;

    assign rr_next = (winner == req_idx_t'(N_REQ - 1)) ? '0 : winner + req_idx_t'(1);

    // Full is taken from registered state only, so a response in the same
    // cycle cannot reopen the request path combinationally.
    assign m_req_o   = rst_ni && (|req_i) && !fifo_full;
    assign handshake = m_req_o && m_gnt_i;
    assign rsp_valid = rst_ni && m_r_valid_i && !fifo_empty;

    always_comb begin
        m_add_o   = '0;
        m_wen_o   = 1'b1;
        m_wdata_o = '0;
        m_be_o    = '0;
        gnt_o     = '0;
        r_valid_o = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (winner == req_idx_t'(k)) begin
                m_add_o   = add_i[k*ADDR_WIDTH +: ADDR_WIDTH];
                m_wen_o   = wen_i[k];
                m_wdata_o = wdata_i[k*DATA_WIDTH +: DATA_WIDTH];
                m_be_o    = be_i[k*BE_W +: BE_W];
                gnt_o[k]  = handshake;
            end
            if (head == req_idx_t'(k)) begin
                r_valid_o[k] = rsp_valid;
            end
        end
    end

    assign r_rdata_o = m_r_rdata_i;
    assign busy_o    = (count != '0);
    assign err_o     = err_q;

    fc_l2_arb_id_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .push  (handshake),
        .pop   (rsp_valid),
        .din   (winner),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (count)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rr_q       <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            err_q      <= 1'b0;
        end else begin
            if (handshake && rr_adv) begin
                rr_q <= rr_next;
            end
            // The lock is set only in the cycle after a stalled request.
            lock_q     <= m_req_o && !m_gnt_i;
            lock_idx_q <= winner;
            if (m_r_valid_i && fifo_empty) begin
                err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fc_l2_arbiter.sv
module tb_fc_l2_arbiter;

`ifdef FC_L2_ARB_FIXED_PRIO_EN
    localparam int N = 3;
`else
    localparam int N = 2;
`endif
    localparam int MO = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req;
    logic [N*AW-1:0] add;
    logic [N-1:0]    wen;
    logic [N*DW-1:0] wdata;
    logic [N*BW-1:0] be;
    logic [N-1:0]    gnt;
    logic [N-1:0]    r_valid;
    logic [DW-1:0]   r_rdata;
    logic            m_req;
    logic [AW-1:0]   m_add;
    logic            m_wen;
    logic [DW-1:0]   m_wdata;
    logic [BW-1:0]   m_be;
    logic            m_gnt;
    logic            m_rv;
    logic [DW-1:0]   m_rdata;
    logic            busy;
    logic            err;

    fc_l2_arbiter #(
        .N_REQ(N), .MAX_OUTSTANDING(MO), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .add_i(add), .wen_i(wen),
        .wdata_i(wdata), .be_i(be), .gnt_o(gnt), .r_valid_o(r_valid),
        .r_rdata_o(r_rdata), .m_req_o(m_req), .m_add_o(m_add), .m_wen_o(m_wen),
        .m_wdata_o(m_wdata), .m_be_o(m_be), .m_gnt_i(m_gnt),
        .m_r_valid_i(m_rv), .m_r_rdata_i(m_rdata), .busy_o(busy), .err_o(err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: the round-robin pointer, the winner being held across
    // a stall, the owners of outstanding transactions in grant order, and the
    // sticky error flag.
    int m_rr      = 0;
    int m_lock    = -1;
    int m_q[$];
    bit m_err     = 1'b0;
    int m_granted = -1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_winner();
        int c;
        if (m_lock >= 0 && req[m_lock]) return m_lock;
`ifdef FC_L2_ARB_FIXED_PRIO_EN
        if (req[0]) return 0;
        for (int i = 0; i < N; i++) begin
            c = (m_rr + i) % N;
            if (c != 0 && req[c]) return c;
        end
`else
        for (int i = 0; i < N; i++) begin
            c = (m_rr + i) % N;
            if (req[c]) return c;
        end
`endif
        return 0;
    endfunction

    // One clock cycle: check every output against the model at the negedge,
    // then advance the model at the posedge. Returns at posedge + 1.
    task automatic step();
        int           w;
        logic         exp_mreq;
        logic         hs;
        logic [N-1:0] one;
        logic [N-1:0] exp_gnt;
        logic [N-1:0] exp_rv;
        one = 1;
        @(negedge clk);
        w        = exp_winner();
        exp_mreq = rst_n && (req != '0) && (m_q.size() < MO);
        hs       = exp_mreq && m_gnt;
        exp_gnt  = hs ? (one << w) : '0;
        exp_rv   = (rst_n && m_rv && m_q.size() > 0) ? (one << m_q[0]) : '0;
        check("m_req", 64'(m_req), 64'(exp_mreq));
        check("gnt", 64'(gnt), 64'(exp_gnt));
        check("r_valid", 64'(r_valid), 64'(exp_rv));
        check("r_rdata", 64'(r_rdata), 64'(m_rdata));
        check("busy", 64'(busy), 64'(m_q.size() != 0));
        check("err", 64'(err), 64'(m_err));
        if (exp_mreq) begin
            check("m_add", 64'(m_add), 64'(add[w*AW +: AW]));
            check("m_wen", 64'(m_wen), 64'(wen[w]));
            check("m_wdata", 64'(m_wdata), 64'(wdata[w*DW +: DW]));
            check("m_be", 64'(m_be), 64'(be[w*BW +: BW]));
        end
        @(posedge clk);
        m_granted = hs ? w : -1;
        if (!rst_n) begin
            m_rr   = 0;
            m_q.delete();
            m_lock = -1;
            m_err  = 1'b0;
        end else begin
            if (m_rv) begin
                if (m_q.size() > 0) void'(m_q.pop_front());
                else m_err = 1'b1;
            end
            if (hs) begin
                m_q.push_back(w);
`ifdef FC_L2_ARB_FIXED_PRIO_EN
                if (w != 0) m_rr = (w + 1) % N;
`else
                m_rr = (w + 1) % N;
`endif
            end
            m_lock = (exp_mreq && !m_gnt) ? w : -1;
        end
        #1;
    endtask

    // Raise requester k's request with a new random payload.
    task automatic raise(input int k);
        req[k]             = 1'b1;
        add[k*AW +: AW]    = $urandom();
        wen[k]             = 1'($urandom_range(0, 1));
        wdata[k*DW +: DW]  = $urandom();
        be[k*BW +: BW]     = BW'($urandom_range(0, (1 << BW) - 1));
    endtask

    // Stop requesting and return every outstanding response.
    task automatic drain();
        req   = '0;
        m_gnt = 1'b0;
        for (int i = 0; i < MO + 2; i++) begin
            m_rv    = (m_q.size() > 0);
            m_rdata = $urandom();
            step();
        end
        m_rv = 1'b0;
    endtask

    initial begin
        rst_n   = 1'b0;
        req     = '0;
        add     = '0;
        wen     = '0;
        wdata   = '0;
        be      = '0;
        m_gnt   = 1'b0;
        m_rv    = 1'b0;
        m_rdata = '0;
        #1;
        step();
        // Requests, grants and responses during reset must all be suppressed.
        raise(0);
        raise(1);
        m_gnt = 1'b1;
        m_rv  = 1'b1;
        step();
        req   = '0;
        m_gnt = 1'b0;
        m_rv  = 1'b0;
        rst_n = 1'b1;
        step();
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_err", 64'(err), 64'd0);

        // Round-robin sharing: both requesters always requesting, each
        // response returned one cycle after its grant.
        raise(0);
        raise(1);
        m_gnt = 1'b1;
        for (int i = 0; i < 8; i++) begin
            m_rv    = (m_q.size() > 0);
            m_rdata = $urandom();
            step();
            if (m_granted >= 0) raise(m_granted);
        end
        drain();

        // Backpressure lock: after a grant to requester 0 the pointer points
        // at 1, but a stalled request from 0 must keep the port.
        raise(0);
        m_gnt = 1'b1;
        step();
        raise(0);
        m_gnt = 1'b0;
        step();
        raise(1);
        step();
        step();
        #1;
        check("lock_add", 64'(m_add), 64'(add[0 +: AW]));
        m_gnt = 1'b1;
        #1;
        check("lock_gnt0", 64'(gnt), 64'd1);
        step();
        req[0] = 1'b0;
        step();
        drain();

        // Outstanding limit: four grants with no response.
        raise(0);
        raise(1);
        m_gnt = 1'b1;
        for (int i = 0; i < MO; i++) begin
            step();
            if (m_granted >= 0) raise(m_granted);
        end
        #1;
        check("full_mreq", 64'(m_req), 64'd0);
        check("full_busy", 64'(busy), 64'd1);
        m_rv = 1'b1;
        #1;
        check("full_mreq_rv", 64'(m_req), 64'd0);
        step();
        m_rv = 1'b0;
        #1;
        check("reopen_mreq", 64'(m_req), 64'd1);
        step();
        drain();

        // In-order routing: grants to 1, then 0, then 1; responses A, B, C.
        m_gnt = 1'b1;
        req = '0; raise(1); step();
        req = '0; raise(0); step();
        req = '0; raise(1); step();
        req   = '0;
        m_gnt = 1'b0;
        m_rv  = 1'b1;
        m_rdata = 32'hA; #1;
        check("route_a", 64'(r_valid), 64'b10);
        check("route_a_data", 64'(r_rdata), 64'hA);
        step();
        m_rdata = 32'hB; #1;
        check("route_b", 64'(r_valid), 64'b01);
        step();
        m_rdata = 32'hC; #1;
        check("route_c", 64'(r_valid), 64'b10);
        step();

        // Spurious response with nothing outstanding.
        #1;
        check("spur_rv", 64'(r_valid), 64'd0);
        step();
        m_rv = 1'b0;
        check("spur_err", 64'(err), 64'd1);

        // Reset with two transactions outstanding.
        raise(0);
        raise(1);
        m_gnt = 1'b1;
        step();
        if (m_granted >= 0) raise(m_granted);
        step();
        req   = '0;
        m_gnt = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        // A stale response after reset is spurious.
        m_rv = 1'b1;
        step();
        m_rv = 1'b0;
        check("stale_err", 64'(err), 64'd1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        // The pointer is back at 0, so requester 0 wins a tie.
        raise(0);
        raise(1);
        m_gnt = 1'b1;
        #1;
        check("rst_rr", 64'(gnt), 64'd1);
        step();
        drain();

`ifdef FC_L2_ARB_FIXED_PRIO_EN
        // Requester 0 always wins. Without it, 1 and 2 alternate.
        m_gnt = 1'b1;
        raise(0); raise(1); raise(2);
        for (int i = 0; i < 3; i++) begin
            m_rv = (m_q.size() > 0);
            #1;
            check("prio0", 64'(gnt), 64'b001);
            step();
            raise(0);
        end
        req[0] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            m_rv = (m_q.size() > 0);
            step();
            if (m_granted >= 0) raise(m_granted);
        end
        drain();
`endif

        // Random traffic, with occasional spurious responses and one reset.
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int k = 0; k < N; k++) begin
                if (m_granted == k) begin
                    if ($urandom_range(0, 1) == 0) req[k] = 1'b0;
                    else raise(k);
                end else if (!req[k] && $urandom_range(0, 2) == 0) begin
                    raise(k);
                end
            end
            m_gnt   = 1'($urandom_range(0, 3) != 0);
            m_rv    = (m_q.size() > 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 40) == 0);
            m_rdata = $urandom();
            rst_n   = (cyc != 300);
            step();
        end
        rst_n = 1'b1;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fc_l2_arbiter.md
Name: fc_l2_arbiter

Overview:
- Shares one FC L2 TCDM-style master port (req/gnt, in-order r_valid) between N_REQ requesters, e.g. the core data port, a debug-module port and a HWPE config/DMA port.
- Arbitration is round-robin.
- A grant-order ID FIFO tracks outstanding transactions and steers each response back to the requester that issued it.
- Sits between the FC core/peripheral masters and the l2_data_master bus of the FC subsystem.

Parameters:
- N_REQ, 2, number of requester ports (2..8).
- MAX_OUTSTANDING, 4, max granted transactions awaiting r_valid (1..16).
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width; be width = DATA_WIDTH/8.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, synchronous, active-low.
- req_i  in  N_REQ  per-requester request.
- add_i  in  N_REQ*ADDR_WIDTH  packed addresses; requester k at slice k.
- wen_i  in  N_REQ  write-enable-n (1 = read).
- wdata_i  in  N_REQ*DATA_WIDTH  packed write data.
- be_i  in  N_REQ*DATA_WIDTH/8  packed byte enables.
- gnt_o  out  N_REQ  per-requester grant.
- r_valid_o  out  N_REQ  per-requester response valid.
- r_rdata_o  out  DATA_WIDTH  response data, broadcast to all requesters.
- m_req_o  out  1  master request.
- m_add_o  out  ADDR_WIDTH  master address.
- m_wen_o  out  1  master write-enable-n.
- m_wdata_o  out  DATA_WIDTH  master write data.
- m_be_o  out  DATA_WIDTH/8  master byte enables.
- m_gnt_i  in  1  master grant.
- m_r_valid_i  in  1  master response valid.
- m_r_rdata_i  in  DATA_WIDTH  master response data.
- busy_o  out  1  at least one transaction outstanding.
- err_o  out  1  sticky: r_valid received with no transaction outstanding.

Behaviour:
- Single clock domain; reset is synchronous and active-low.
- Reset state: rr_q=0, FIFO empty, count_q=0, err_q=0.
- While rst_ni=0, m_req_o, gnt_o and r_valid_o are forced to 0.
- After reset: busy_o=0, err_o=0, r_valid_o=0.
- Protocol: a requester holds req and its payload stable until gnt.
  - gnt is same-cycle combinational.
  - Responses arrive one or more cycles after gnt, strictly in grant order.
- Winner selection (combinational): the first index with req_i set, scanning rr_q, rr_q+1, … modulo N_REQ.
- The winner's payload is muxed onto m_add_o, m_wen_o, m_wdata_o and m_be_o.
- m_req_o = any(req_i) & ~fifo_full.
- gnt_o[winner] = m_gnt_i & m_req_o; all other gnt_o bits are 0.
- No m_req_o dropping: if m_gnt_i=0, the winner does not change while it keeps requesting.
  - Implemented by a lock register holding the winner index while m_req_o & ~m_gnt_i.
- On handshake (m_req_o & m_gnt_i):
  - push winner index into the ID FIFO;
  - rr_q <= (winner+1) mod N_REQ.
- Full FIFO (count_q == MAX_OUTSTANDING): m_req_o=0, even if m_r_valid_i=1 in the same cycle. There is no combinational path from r_valid to req.
- Response path:
  - When m_r_valid_i=1 and the FIFO is not empty: r_valid_o[fifo_head]=1 in the same cycle, and the FIFO pops.
  - r_rdata_o = m_r_rdata_i at all times.
- Spurious response (m_r_valid_i=1 with FIFO empty):
  - no r_valid_o asserted;
  - err_q <= 1 (sticky until reset);
  - count unchanged.
- Simultaneous push and pop: count_q unchanged and the FIFO pointers both advance. A push and pop together are legal when count_q < MAX_OUTSTANDING.
- count_q width = $clog2(MAX_OUTSTANDING+1); FIFO pointers wrap modulo MAX_OUTSTANDING.
- busy_o = (count_q != 0), registered from state.
- Reset mid-operation discards all outstanding IDs. Later r_valid pulses from the old transactions count as spurious and set err_o.

Optional Feature:
- Macro FC_L2_ARB_FIXED_PRIO_EN.
- Defined: requester 0 has absolute priority and indices 1..N_REQ-1 are round-robin among themselves. rr_q only advances on grants to indices ≥1. The lock rule still applies.
- Undefined: pure round-robin as above.

Decomposition:
- Package fc_l2_arb_pkg holds:
  - localparam MAX_N_REQ=8;
  - function rr_pick(req, ptr) returning the winner index;
  - typedef for the requester index width (logic [2:0]).
- Sub-module fc_l2_arb_id_fifo: synchronous FIFO of requester indices, depth MAX_OUTSTANDING, with push/pop/full/empty/count outputs and synchronous active-low reset.

Test Plan:
- Round-robin sharing: N_REQ=2, both req_i held high, m_gnt_i=1, r_valid 1 cycle later. Required: gnt_o alternates 01,10,01,10 and each r_valid_o pulse matches its grantee.
- Backpressure lock: req_i=01, m_gnt_i=0 for 3 cycles, req_i[1] rises in cycle 2. Required: m_add_o stays = add of requester 0 until m_gnt_i=1, then requester 1 is granted next.
- Outstanding limit: MAX_OUTSTANDING=4, 4 grants issued, no responses, req still high. Required: m_req_o=0 and busy_o=1. After one m_r_valid_i, m_req_o=1 on the following cycle.
- In-order routing: grants issued to requester 1, then 0, then 1; three r_valid pulses with rdata 0xA, 0xB, 0xC. Required: r_valid_o = 10, 01, 10 with matching r_rdata_o.
- Spurious and reset: m_r_valid_i=1 with FIFO empty gives err_o=1 and r_valid_o=0. A rst_ni low pulse with 2 outstanding gives err_o=0, busy_o=0, rr_q=0 after release.
- FC_L2_ARB_FIXED_PRIO_EN: N_REQ=3, all req high. Required: requester 0 is granted every cycle. With req_i=110, grants alternate between requesters 1 and 2.
